// File: rtl/rom_boot_loader.sv
// rtl/rom_boot_loader.sv - byte-stream ROM image loader with checksum and core reset hold
// Optional LOADER_TIMEOUT_EN: abort a frame after TIMEOUT idle cycles between bytes.
module rom_boot_loader #(
    parameter int          ADDR_W    = 12,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int unsigned TIMEOUT   = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        rom_we,
    output logic [31:0] rom_addr,
    output logic [31:0] rom_data,
    output logic        core_rst,
    output logic        load_done,
    output logic        load_err
);

    typedef enum logic [2:0] {
        IDLE, CNT0, CNT1, DATA, WRITE, CSUM, DONE, ERR
    } state_t;

    localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_W);

    state_t      state;
    state_t      state_nxt;
    logic        accept;
    logic        is_sync;
    logic        timeout;
    logic [7:0]  cnt_lo;
    logic [15:0] count;
    logic [15:0] idx;
    logic [1:0]  lane;
    logic [23:0] word_buf;
    logic [7:0]  csum;

    assign rx_ready = !rst && (state != WRITE);
    assign accept   = rx_valid && rx_ready;
    assign is_sync  = (rx_data == SYNC_BYTE);

`ifdef LOADER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] timer;
    logic          counting;

    // Only the in-frame states watch for a stalled byte source.
    assign counting = (state != IDLE) && (state != DONE) && (state != ERR);
    assign timeout  = counting && !accept && (timer >= TW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer <= '0;
        end else if (accept || !counting) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end
`else
    localparam int unsigned unused_timeout = TIMEOUT;

    assign timeout = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept && is_sync) state_nxt = CNT0;
            end
            CNT0: begin
                if (accept) state_nxt = CNT1;
            end
            CNT1: begin
                if (accept) begin
                    if ({1'b0, rx_data, cnt_lo} > MAX_WORDS) state_nxt = ERR;
                    else if ({rx_data, cnt_lo} == 16'd0)     state_nxt = CSUM;
                    else                                     state_nxt = DATA;
                end
            end
            DATA: begin
                if (accept && lane == 2'd3) state_nxt = WRITE;
            end
            WRITE: begin
                state_nxt = (idx == count - 16'd1) ? CSUM : DATA;
            end
            CSUM: begin
                if (accept) state_nxt = (rx_data == csum) ? DONE : ERR;
            end
            DONE: begin
                state_nxt = DONE;
            end
            ERR: begin
                if (accept && is_sync) state_nxt = CNT0;
            end
            default: state_nxt = IDLE;
        endcase
        if (timeout) state_nxt = ERR;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rom_we    <= 1'b0;
            rom_addr  <= '0;
            rom_data  <= '0;
            core_rst  <= 1'b1;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            cnt_lo    <= '0;
            count     <= '0;
            idx       <= '0;
            lane      <= '0;
            word_buf  <= '0;
            csum      <= '0;
        end else begin
            state  <= state_nxt;
            rom_we <= 1'b0;
            case (state)
                IDLE, ERR: begin
                    if (accept && is_sync) begin
                        load_err <= 1'b0;
                        csum     <= '0;
                        idx      <= '0;
                        lane     <= '0;
                    end
                end
                CNT0: begin
                    if (accept) cnt_lo <= rx_data;
                end
                CNT1: begin
                    if (accept) count <= {rx_data, cnt_lo};
                end
                DATA: begin
                    if (accept) begin
                        csum <= csum + rx_data;
                        lane <= lane + 2'd1;
                        case (lane)
                            2'd0: word_buf[7:0]   <= rx_data;
                            2'd1: word_buf[15:8]  <= rx_data;
                            2'd2: word_buf[23:16] <= rx_data;
                            default: begin
                                // Register the write so rom_we lands one cycle after the last byte.
                                rom_we   <= 1'b1;
                                rom_addr <= {14'd0, idx, 2'b00};
                                rom_data <= {rx_data, word_buf};
                            end
                        endcase
                    end
                end
                WRITE: begin
                    idx <= idx + 16'd1;
                end
                CSUM: begin
                    if (accept && rx_data == csum && !timeout) begin
                        load_done <= 1'b1;
                        core_rst  <= 1'b0;
                    end
                end
                default: ;
            endcase
            if (state_nxt == ERR && state != ERR) load_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rom_boot_loader.sv
// tb/tb_rom_boot_loader.sv - directed scoreboard bench for rom_boot_loader
module tb_rom_boot_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        rom_we;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        core_rst;
    logic        load_done;
    logic        load_err;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          stalls   = 0;
    logic [63:0] sb[$];
    logic [31:0] img[$];

    always #5 clk = ~clk;

    rom_boot_loader #(.ADDR_W(12), .SYNC_BYTE(8'hA5), .TIMEOUT(100)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rom_we(rom_we), .rom_addr(rom_addr), .rom_data(rom_data),
        .core_rst(core_rst), .load_done(load_done), .load_err(load_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ROM write monitor: every strobe must match the next scoreboard entry.
    always @(negedge clk) begin
        if (!rst && rx_valid && !rx_ready) stalls++;
        if (!rst && rom_we) begin
            if (sb.size() == 0) begin
                check("unexpected_rom_we", 32'd1, 32'd0);
            end else begin
                logic [63:0] e;
                e = sb.pop_front();
                check("rom_addr", rom_addr, e[63:32]);
                check("rom_data", rom_data, e[31:0]);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int guard;
        guard    = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) check("rx_ready_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_reset();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        rst      = 1'b1;
        #1;
        check("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
        check("rst_rom_we", {31'd0, rom_we}, 32'd0);
        check("rst_rom_addr", rom_addr, 32'd0);
        check("rst_rom_data", rom_data, 32'd0);
        check("rst_core_rst", {31'd0, core_rst}, 32'd1);
        check("rst_load_done", {31'd0, load_done}, 32'd0);
        check("rst_load_err", {31'd0, load_err}, 32'd0);
        @(negedge clk);
        sb.delete();
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_body(input logic [7:0] csum_flip);
        logic [7:0] sum;
        logic [7:0] b;
        logic [31:0] w;
        sum = 8'h00;
        for (int i = 0; i < img.size(); i++) begin
            w = img[i];
            for (int k = 0; k < 4; k++) begin
                b = w[8*k +: 8];
                sum = sum + b;
                if (k == 3) sb.push_back({32'(i * 4), w});
                send_byte(b);
            end
        end
        send_byte(sum ^ csum_flip);
        idle(3);
    endtask

    task automatic send_frame(input logic [7:0] csum_flip);
        int n;
        n = img.size();
        send_byte(8'hA5);
        send_byte(n[7:0]);
        send_byte(n[15:8]);
        send_body(csum_flip);
    endtask

    task automatic check_loaded(input string tag);
        check({tag, "_done"}, {31'd0, load_done}, 32'd1);
        check({tag, "_core_rst"}, {31'd0, core_rst}, 32'd0);
        check({tag, "_err"}, {31'd0, load_err}, 32'd0);
        check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int n;
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        @(negedge clk);

        // Two-word program, preceded by junk bytes that IDLE must drop.
        apply_reset();
        check("idle_rx_ready", {31'd0, rx_ready}, 32'd1);
        send_byte(8'h00);
        send_byte(8'h13);
        img = '{32'h00000013, 32'h00100093};
        stalls = 0;
        send_frame(8'h00);
        check_loaded("prog2");
        check("prog2_stalls", 32'(stalls), 32'd2);
        send_byte(8'hA5);
        idle(2);
        check("done_sticky", {31'd0, load_done}, 32'd1);
        check("done_rx_ready", {31'd0, rx_ready}, 32'd1);

        // Bad checksum: word still written, error reported, then empty image recovers.
        apply_reset();
        img = '{32'h44332211};
        send_frame(8'hAA);
        check("badcs_err", {31'd0, load_err}, 32'd1);
        check("badcs_core_rst", {31'd0, core_rst}, 32'd1);
        check("badcs_done", {31'd0, load_done}, 32'd0);
        check("badcs_sb_empty", 32'(sb.size()), 32'd0);
        send_byte(8'h00);
        idle(1);
        check("err_sticky", {31'd0, load_err}, 32'd1);
        img.delete();
        send_frame(8'h00);
        check_loaded("empty");

        // Oversize count errors right after CNT_HI.
        apply_reset();
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h10);
        idle(2);
        check("oversize_err", {31'd0, load_err}, 32'd1);
        check("oversize_core_rst", {31'd0, core_rst}, 32'd1);

        // Exactly full ROM, back-to-back bytes.
        apply_reset();
        img.delete();
        for (int i = 0; i < 4096; i++) img.push_back($urandom);
        stalls = 0;
        send_frame(8'h00);
        check_loaded("full");
        check("full_stalls", 32'(stalls), 32'd4096);
        check("full_last_addr", rom_addr, 32'h3FFC);

        // Reset mid-frame, then a clean reload.
        apply_reset();
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        apply_reset();
        img = '{$urandom, $urandom, $urandom};
        send_frame(8'h00);
        check_loaded("reload");

        // Stall after CNT_LO.
        apply_reset();
        img = '{32'h01020304, 32'h05060708};
        n = img.size();
        send_byte(8'hA5);
        send_byte(n[7:0]);
        idle(150);
`ifdef LOADER_TIMEOUT_EN
        check("timeout_err", {31'd0, load_err}, 32'd1);
        check("timeout_core_rst", {31'd0, core_rst}, 32'd1);
`else
        check("stall_no_err", {31'd0, load_err}, 32'd0);
        check("stall_rx_ready", {31'd0, rx_ready}, 32'd1);
        send_byte(n[15:8]);
        send_body(8'h00);
        check_loaded("stall");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
